// File: rtl/channel_cu_emulator.sv
// Device-side control-unit model for Parallel Channel "A": answers selection for one
// address, takes a command, presents status and moves bytes against a small buffer.
module channel_cu_emulator #(
    parameter logic [7:0]  ADDRESS    = 8'h10,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            a_bus_out,
    input  logic                  a_operational_out,
    input  logic                  a_hold_out,
    input  logic                  a_select_out,
    input  logic                  a_address_out,
    input  logic                  a_command_out,
    input  logic                  a_service_out,
    input  logic                  a_suppress_out,
    output logic [7:0]            a_bus_in,
    output logic                  a_operational_in,
    output logic                  a_select_in,
    output logic                  a_address_in,
    output logic                  a_status_in,
    output logic                  a_service_in,
    output logic                  a_request_in,
    input  logic                  busy,
    input  logic                  buf_wr_en,
    input  logic [DEPTH_LOG2-1:0] buf_wr_addr,
    input  logic [7:0]            buf_wr_data,
    output logic [7:0]            command_out,
    output logic                  command_strobe,
    output logic [7:0]            rx_data,
    output logic                  rx_strobe,
    output logic [DEPTH_LOG2:0]   xfer_count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    localparam logic [7:0] ST_BUSY   = 8'h10;
    localparam logic [7:0] ST_CHK    = 8'h0E;
    localparam logic [7:0] ST_ENDING = 8'h0C;
    localparam logic [7:0] CMD_TEST  = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;

    typedef enum logic [3:0] {
        IDLE, PROPAGATE, SEL_OP, ADDR_IN, CMD_DROP, INIT_STATUS, INIT_ACK,
        DATA_REQ, DATA_ACK, STOP_ACK, END_STATUS, END_ACK, DISCONNECT
    } state_t;

    state_t state, state_next;

    logic [7:0]            mem [DEPTH];
    logic [7:0]            status_q;
    logic                  busy_q;
    logic [DEPTH_LOG2-1:0] xfer_idx;

    logic                  sys_rst_c, accept_c, step_c, capture_c, select_hit_c;
    logic [7:0]            init_status_c;
    logic [7:0]            bus_d;
    logic                  op_d, sel_d, addr_d, stat_d, svc_d;

    // Hold and suppress have no effect on this device.
    logic unused_tags;
    assign unused_tags  = &{1'b0, a_hold_out, a_suppress_out};
    assign a_request_in = 1'b0;
    assign xfer_idx     = xfer_count[DEPTH_LOG2-1:0];

    // Next state, handshake events and registered-output values
    always_comb begin
        state_next    = state;
        sys_rst_c     = !a_operational_out && (state != IDLE);
        select_hit_c  = 1'b0;
        accept_c      = 1'b0;
        step_c        = 1'b0;
        capture_c     = 1'b0;
        init_status_c = 8'h00;
        bus_d         = 8'h00;
        op_d          = 1'b0;
        sel_d         = 1'b0;
        addr_d        = 1'b0;
        stat_d        = 1'b0;
        svc_d         = 1'b0;

        if (busy_q) begin
            init_status_c = ST_BUSY;
        end else if (a_bus_out != CMD_TEST && a_bus_out != CMD_WRITE && a_bus_out != CMD_READ) begin
            init_status_c = ST_CHK;
        end

        case (state)
            IDLE: begin
                if (a_select_out && a_address_out) begin
                    if (a_bus_out == ADDRESS && !a_operational_in) begin
                        state_next   = SEL_OP;
                        select_hit_c = 1'b1;
                    end else begin
                        state_next = PROPAGATE;
                    end
                end
            end
            PROPAGATE:   if (!a_select_out) state_next = IDLE;
            SEL_OP:      state_next = ADDR_IN;
            ADDR_IN: begin
                if (a_command_out) begin
                    state_next = CMD_DROP;
                    accept_c   = 1'b1;
                end
            end
            CMD_DROP:    if (!a_command_out) state_next = INIT_STATUS;
            INIT_STATUS: if (a_service_out) state_next = INIT_ACK;
            INIT_ACK: begin
                if (!a_service_out) begin
                    state_next = (status_q != 8'h00 || command_out == CMD_TEST) ? DISCONNECT : DATA_REQ;
                end
            end
            DATA_REQ: begin
                // Stop wins over a simultaneous service; no byte is counted.
                if (a_command_out) begin
                    state_next = STOP_ACK;
                end else if (a_service_out) begin
                    state_next = DATA_ACK;
                    step_c     = 1'b1;
                    capture_c  = (command_out == CMD_WRITE);
                end
            end
            DATA_ACK: begin
                if (!a_service_out) begin
                    state_next = (xfer_count == CW'(DEPTH)) ? END_STATUS : DATA_REQ;
                end
            end
            STOP_ACK:    if (!a_command_out) state_next = END_STATUS;
            END_STATUS:  if (a_service_out) state_next = END_ACK;
            END_ACK:     if (!a_service_out) state_next = DISCONNECT;
            DISCONNECT:  state_next = IDLE;
            default:     state_next = IDLE;
        endcase

        if (sys_rst_c) begin
            state_next   = IDLE;
            select_hit_c = 1'b0;
            accept_c     = 1'b0;
            step_c       = 1'b0;
            capture_c    = 1'b0;
        end

        case (state_next)
            PROPAGATE:  sel_d = 1'b1;
            SEL_OP:     op_d  = 1'b1;
            ADDR_IN: begin
                op_d   = 1'b1;
                addr_d = 1'b1;
                bus_d  = ADDRESS;
            end
            INIT_STATUS: begin
                op_d   = 1'b1;
                stat_d = 1'b1;
                bus_d  = status_q;
            end
            DATA_REQ: begin
                op_d  = 1'b1;
                svc_d = 1'b1;
                if (command_out == CMD_READ) bus_d = mem[xfer_idx];
            end
            END_STATUS: begin
                op_d   = 1'b1;
                stat_d = 1'b1;
                bus_d  = ST_ENDING;
            end
            CMD_DROP, INIT_ACK, DATA_ACK, STOP_ACK, END_ACK: op_d = 1'b1;
            default: ;
        endcase
    end

    // State, tags and host-visible registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            a_bus_in         <= 8'h00;
            a_operational_in <= 1'b0;
            a_select_in      <= 1'b0;
            a_address_in     <= 1'b0;
            a_status_in      <= 1'b0;
            a_service_in     <= 1'b0;
            command_out      <= 8'h00;
            command_strobe   <= 1'b0;
            rx_data          <= 8'h00;
            rx_strobe        <= 1'b0;
            xfer_count       <= '0;
            status_q         <= 8'h00;
            busy_q           <= 1'b0;
        end else begin
            state            <= state_next;
            a_bus_in         <= bus_d;
            a_operational_in <= op_d;
            a_select_in      <= sel_d;
            a_address_in     <= addr_d;
            a_status_in      <= stat_d;
            a_service_in     <= svc_d;
            command_strobe   <= accept_c;
            rx_strobe        <= capture_c;
            if (select_hit_c) busy_q <= busy;
            if (accept_c) begin
                command_out <= a_bus_out;
                status_q    <= init_status_c;
                xfer_count  <= '0;
            end else if (step_c) begin
                xfer_count  <= xfer_count + CW'(1);
            end
            if (capture_c) rx_data <= a_bus_out;
        end
    end

    // Buffer is not reset; a transfer write overrides a same-cycle host write.
    always_ff @(posedge clk) begin
        if (buf_wr_en) mem[buf_wr_addr] <= buf_wr_data;
        if (capture_c) mem[xfer_idx] <= a_bus_out;
    end

endmodule

// File: tb/tb_channel_cu_emulator.sv
// Randomized channel-side bench for channel_cu_emulator with a buffer/status reference model.
module tb_channel_cu_emulator;

    localparam logic [7:0] ADDR  = 8'h10;
    localparam int         DEPTH = 16;
    localparam int W_OP = 0, W_ADDR = 1, W_STAT = 2, W_SVC = 3, W_SEL = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] a_bus_out;
    logic       a_operational_out, a_hold_out, a_select_out, a_address_out;
    logic       a_command_out, a_service_out, a_suppress_out;
    logic [7:0] a_bus_in;
    logic       a_operational_in, a_select_in, a_address_in, a_status_in, a_service_in, a_request_in;
    logic       busy, buf_wr_en;
    logic [3:0] buf_wr_addr;
    logic [7:0] buf_wr_data;
    logic [7:0] command_out, rx_data;
    logic       command_strobe, rx_strobe;
    logic [4:0] xfer_count;

    channel_cu_emulator #(.ADDRESS(ADDR), .DEPTH_LOG2(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_bus_out(a_bus_out), .a_operational_out(a_operational_out), .a_hold_out(a_hold_out),
        .a_select_out(a_select_out), .a_address_out(a_address_out), .a_command_out(a_command_out),
        .a_service_out(a_service_out), .a_suppress_out(a_suppress_out),
        .a_bus_in(a_bus_in), .a_operational_in(a_operational_in), .a_select_in(a_select_in),
        .a_address_in(a_address_in), .a_status_in(a_status_in), .a_service_in(a_service_in),
        .a_request_in(a_request_in), .busy(busy), .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr),
        .buf_wr_data(buf_wr_data), .command_out(command_out), .command_strobe(command_strobe),
        .rx_data(rx_data), .rx_strobe(rx_strobe), .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] mbuf [DEPTH];
    logic [7:0] rx_q [$];
    int         cmd_strobes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx_strobe) rx_q.push_back(rx_data);
        if (command_strobe) cmd_strobes++;
    end

    function automatic logic tag_of(input int sel);
        case (sel)
            W_OP:    return a_operational_in;
            W_ADDR:  return a_address_in;
            W_STAT:  return a_status_in;
            W_SVC:   return a_service_in;
            default: return a_select_in;
        endcase
    endfunction

    task automatic wait_for(input int sel, input logic val, input string tag);
        logic s;
        s = tag_of(sel);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            s = tag_of(sel);
            if (s == val) return;
        end
        check(tag, 32'(s), 32'(val));
    endtask

    function automatic logic [7:0] exp_status(input logic [7:0] cmd, input logic b);
        if (b) return 8'h10;
        if (cmd == 8'h00 || cmd == 8'h01 || cmd == 8'h02) return 8'h00;
        return 8'h0E;
    endfunction

    task automatic host_write(input int addr, input logic [7:0] data);
        @(negedge clk);
        buf_wr_en   = 1'b1;
        buf_wr_addr = 4'(addr);
        buf_wr_data = data;
        mbuf[addr]  = data;
        @(negedge clk);
        buf_wr_en = 1'b0;
    endtask

    task automatic idle_channel();
        a_bus_out = 8'h00; a_select_out = 1'b0; a_address_out = 1'b0;
        a_command_out = 1'b0; a_service_out = 1'b0; busy = 1'b0;
    endtask

    // Selection, command and initial-status handshake; returns the modelled status.
    task automatic start_op(input logic [7:0] cmd, input logic b, output logic [7:0] st);
        st = exp_status(cmd, b);
        @(negedge clk);
        busy = b; a_bus_out = ADDR; a_select_out = 1'b1; a_address_out = 1'b1;
        wait_for(W_OP, 1'b1, "op_up");
        wait_for(W_ADDR, 1'b1, "addr_in_up");
        check("addr_bus", 32'(a_bus_in), 32'(ADDR));
        a_select_out = 1'b0; a_address_out = 1'b0; busy = 1'b0;
        a_bus_out = cmd; a_command_out = 1'b1;
        wait_for(W_ADDR, 1'b0, "addr_in_down");
        a_command_out = 1'b0; a_bus_out = 8'h00;
        wait_for(W_STAT, 1'b1, "init_status_up");
        check("init_status", 32'(a_bus_in), 32'(st));
        check("command_out", 32'(command_out), 32'(cmd));
        a_service_out = 1'b1;
        wait_for(W_STAT, 1'b0, "init_status_down");
        a_service_out = 1'b0;
    endtask

    task automatic do_op(input logic [7:0] cmd, input logic b, input int n,
                         input bit stop_svc, input bit count_down);
        logic [7:0] st, data;
        int done_n;
        rx_q.delete();
        cmd_strobes = 0;
        done_n = 0;
        start_op(cmd, b, st);
        if (st == 8'h00 && cmd != 8'h00) begin
            for (int i = 0; i < n; i++) begin
                wait_for(W_SVC, 1'b1, "svc_up");
                if (cmd == 8'h02) begin
                    check("read_byte", 32'(a_bus_in), 32'(mbuf[i]));
                end else begin
                    data = count_down ? 8'(n - i) : 8'($urandom);
                    a_bus_out = data;
                    mbuf[i] = data;
                end
                a_service_out = 1'b1;
                wait_for(W_SVC, 1'b0, "svc_down");
                a_service_out = 1'b0; a_bus_out = 8'h00;
                done_n++;
            end
            if (n < DEPTH) begin
                wait_for(W_SVC, 1'b1, "svc_before_stop");
                a_command_out = 1'b1; a_service_out = stop_svc;
                wait_for(W_SVC, 1'b0, "stop_ack");
                a_command_out = 1'b0; a_service_out = 1'b0;
            end
            wait_for(W_STAT, 1'b1, "end_status_up");
            check("end_status", 32'(a_bus_in), 32'h0C);
            a_service_out = 1'b1;
            wait_for(W_STAT, 1'b0, "end_status_down");
            a_service_out = 1'b0;
        end
        wait_for(W_OP, 1'b0, "op_down");
        check("xfer_count", 32'(xfer_count), 32'(done_n));
        check("cmd_strobes", 32'(cmd_strobes), 32'd1);
        if (cmd == 8'h01 && st == 8'h00) begin
            check("rx_count", 32'(rx_q.size()), 32'(n));
            for (int i = 0; i < n && i < rx_q.size(); i++) check("rx_byte", 32'(rx_q[i]), 32'(mbuf[i]));
        end else begin
            check("rx_count", 32'(rx_q.size()), 32'd0);
        end
    endtask

    task automatic foreign_select();
        @(negedge clk);
        a_bus_out = 8'h20; a_select_out = 1'b1; a_address_out = 1'b1;
        @(negedge clk);
        check("prop_select_in", 32'(a_select_in), 32'd1);
        @(negedge clk);
        check("prop_op_in", 32'(a_operational_in), 32'd0);
        idle_channel();
        @(negedge clk);
        check("prop_release", 32'({a_select_in, a_operational_in}), 32'd0);
    endtask

    initial begin
        logic [7:0] st, cmd;
        int n;
        reset_n = 1'b0;
        a_operational_out = 1'b1; a_hold_out = 1'b0; a_suppress_out = 1'b0;
        buf_wr_en = 1'b0; buf_wr_addr = 4'h0; buf_wr_data = 8'h00;
        idle_channel();
        #12;
        check("reset_outputs", 32'({a_operational_in, a_select_in, a_address_in, a_status_in,
                                    a_service_in, a_request_in, a_bus_in, command_out, xfer_count}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) host_write(i, 8'($urandom));

        do_op(8'h01, 1'b0, 3, 1'b0, 1'b1);
        host_write(0, 8'hA5);
        host_write(1, 8'h5A);
        do_op(8'h02, 1'b0, 2, 1'b0, 1'b0);
        foreign_select();
        do_op(8'h01, 1'b1, 0, 1'b0, 1'b0);
        do_op(8'h07, 1'b0, 0, 1'b0, 1'b0);
        do_op(8'h00, 1'b0, 0, 1'b0, 1'b0);
        do_op(8'h01, 1'b0, 2, 1'b1, 1'b0);
        do_op(8'h02, 1'b0, DEPTH, 1'b0, 1'b0);
        do_op(8'h01, 1'b0, DEPTH, 1'b0, 1'b0);
        do_op(8'h02, 1'b0, 0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a data request
        start_op(8'h01, 1'b0, st);
        wait_for(W_SVC, 1'b1, "svc_before_reset");
        #2 reset_n = 1'b0;
        #1 check("async_reset_tags", 32'({a_operational_in, a_service_in, a_status_in, a_address_in,
                                          a_select_in, a_bus_in, command_out, xfer_count}), 32'd0);
        @(negedge clk);
        idle_channel();
        reset_n = 1'b1;
        do_op(8'h02, 1'b0, 3, 1'b0, 1'b0);

        // Channel drops operational-out while a byte is requested
        start_op(8'h02, 1'b0, st);
        wait_for(W_SVC, 1'b1, "svc_before_sysrst");
        a_operational_out = 1'b0;
        @(negedge clk);
        check("sys_reset_tags", 32'({a_operational_in, a_service_in, a_status_in, a_bus_in}), 32'd0);
        a_operational_out = 1'b1;
        idle_channel();
        do_op(8'h01, 1'b0, 4, 1'b0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 4))
                0:       cmd = 8'h00;
                1, 2:    cmd = 8'($urandom_range(1, 2));
                3:       cmd = 8'h01;
                default: cmd = 8'($urandom);
            endcase
            n = ($urandom_range(0, 7) == 0) ? DEPTH : int'($urandom_range(0, 5));
            if ($urandom_range(0, 2) == 0) host_write(int'($urandom_range(0, DEPTH - 1)), 8'($urandom));
            do_op(cmd, 1'($urandom_range(0, 4) == 0), n, 1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 3) == 0) foreign_select();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
